// File: rtl/pll_rst_pkg.sv
// ============================================================
// Package  : pll_rst_pkg
// Desc     : Shared state type and default constants for the PLL reset sequencer
// Revision : 1.0
// ============================================================
`default_nettype none

package pll_rst_pkg;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        STABLE = 2'd1,
        CORE   = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4096;
    localparam int DEF_VIDEO_DELAY   = 16;
    localparam int DEF_CE_DIV        = 5;
    localparam int LOSS_CNT_W        = 8;

    // Bits needed for a counter running 0..terminal-1, never less than one.
    function automatic int cnt_width(input int terminal);
        return (terminal > 1) ? $clog2(terminal) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_lock_reset_seq_sync_ff.sv
// ============================================================
// Module   : sync_ff
// Desc     : STAGES-deep single-bit synchronizer, synchronous active-low reset
// Revision : 1.0
// ============================================================
`default_nettype none

module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pll_lock_reset_seq.sv
// ============================================================
// Module   : pll_lock_reset_seq
// Desc     : Qualifies PLL lock, sequences core/video reset release and makes
//            the pixel clock enable. Optional macro: LOCK_LOSS_CNT_EN
// Revision : 1.0
// ============================================================
`default_nettype none

module pll_lock_reset_seq
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int VIDEO_DELAY   = DEF_VIDEO_DELAY,
    parameter int CE_DIV        = DEF_CE_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pll_lock,
    output logic core_rst_n,
    output logic video_rst_n,
    output logic pix_ce,
    output logic ready
`ifdef LOCK_LOSS_CNT_EN
    ,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
`endif
);

    localparam int c_stab_w = cnt_width(STABLE_CYCLES);
    localparam int c_dly_w  = cnt_width(VIDEO_DELAY);
    localparam int c_ce_w   = cnt_width(CE_DIV);

    localparam logic [c_stab_w-1:0] c_stab_last = c_stab_w'(STABLE_CYCLES - 1);
    localparam logic [c_dly_w-1:0]  c_dly_last  = c_dly_w'(VIDEO_DELAY - 1);
    localparam logic [c_ce_w-1:0]   c_ce_last   = c_ce_w'(CE_DIV - 1);

    logic                w_lock_s;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_stab_w-1:0] r_stab_cnt;
    logic [c_stab_w-1:0] w_stab_cnt_nxt;
    logic [c_dly_w-1:0]  r_dly_cnt;
    logic [c_dly_w-1:0]  w_dly_cnt_nxt;
    logic [c_ce_w-1:0]   r_ce_cnt;
    logic [c_ce_w-1:0]   w_ce_cnt_nxt;
    logic [c_ce_w-1:0]   w_ce_inc;
    logic                w_core_nxt;
    logic                w_run_nxt;
    logic                w_pix_nxt;
    logic                r_core_rst_n;
    logic                r_video_rst_n;
    logic                r_ready;
    logic                r_pix_ce;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_lock),
        .q       (w_lock_s)
    );

    // Lock loss is checked first so it overrides any count completion.
    always_comb begin
        w_state_nxt    = r_state;
        w_stab_cnt_nxt = r_stab_cnt;
        w_dly_cnt_nxt  = r_dly_cnt;
        if (!w_lock_s) begin
            w_state_nxt    = WAIT;
            w_stab_cnt_nxt = '0;
            w_dly_cnt_nxt  = '0;
        end else begin
            case (r_state)
                WAIT: begin
                    w_state_nxt    = STABLE;
                    w_stab_cnt_nxt = '0;
                end
                STABLE: begin
                    if (r_stab_cnt == c_stab_last) begin
                        w_state_nxt   = CORE;
                        w_dly_cnt_nxt = '0;
                    end else begin
                        w_stab_cnt_nxt = r_stab_cnt + 1'b1;
                    end
                end
                CORE: begin
                    if (r_dly_cnt == c_dly_last) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_dly_cnt_nxt = r_dly_cnt + 1'b1;
                    end
                end
                RUN: begin
                    w_state_nxt = RUN;
                end
                default: begin
                    w_state_nxt = WAIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= WAIT;
            r_stab_cnt <= '0;
            r_dly_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_stab_cnt <= w_stab_cnt_nxt;
            r_dly_cnt  <= w_dly_cnt_nxt;
        end
    end

    // The divider only advances once core_rst_n has been high for a cycle, so the
    // first enable lands on the CE_DIV-th released cycle and dies with the reset.
    always_comb begin
        w_core_nxt   = (w_state_nxt == CORE) || (w_state_nxt == RUN);
        w_run_nxt    = (w_state_nxt == RUN);
        w_ce_inc     = (r_ce_cnt == c_ce_last) ? '0 : r_ce_cnt + 1'b1;
        w_ce_cnt_nxt = (w_core_nxt && r_core_rst_n) ? w_ce_inc : '0;
        w_pix_nxt    = w_core_nxt && r_core_rst_n && (w_ce_inc == c_ce_last);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_core_rst_n  <= 1'b0;
            r_video_rst_n <= 1'b0;
            r_ready       <= 1'b0;
            r_ce_cnt      <= '0;
            r_pix_ce      <= 1'b0;
        end else begin
            r_core_rst_n  <= w_core_nxt;
            r_video_rst_n <= w_run_nxt;
            r_ready       <= w_run_nxt;
            r_ce_cnt      <= w_ce_cnt_nxt;
            r_pix_ce      <= w_pix_nxt;
        end
    end

    assign core_rst_n  = r_core_rst_n;
    assign video_rst_n = r_video_rst_n;
    assign ready       = r_ready;
    assign pix_ce      = r_pix_ce;

`ifdef LOCK_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] r_loss_cnt;

    // Only CORE and RUN count: a drop there is a real loss, drops in STABLE are glitches.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_loss_cnt <= '0;
        end else if (((r_state == CORE) || (r_state == RUN)) && !w_lock_s
                     && (r_loss_cnt != {LOSS_CNT_W{1'b1}})) begin
            r_loss_cnt <= r_loss_cnt + 1'b1;
        end
    end

    assign lock_loss_cnt = r_loss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_reset_seq.sv
// ============================================================
// Module   : tb_pll_lock_reset_seq
// Desc     : Self-checking bench for pll_lock_reset_seq against a run-length model
// Revision : 1.0
// ============================================================
`default_nettype none

module tb_pll_lock_reset_seq;

    localparam int SYNC   = 2;
    localparam int STABLE = 8;
    localparam int VIDEO  = 4;
    localparam int CEDIV  = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic pll_lock = 1'b0;
    logic core_rst_n;
    logic video_rst_n;
    logic pix_ce;
    logic ready;
`ifdef LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pll_lock_reset_seq #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .VIDEO_DELAY   (VIDEO),
        .CE_DIV        (CEDIV)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pll_lock    (pll_lock),
        .core_rst_n  (core_rst_n),
        .video_rst_n (video_rst_n),
        .pix_ce      (pix_ce),
        .ready       (ready)
`ifdef LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model: lock_s is pll_lock delayed SYNC edges (zeros after reset); outputs
    // follow from how long lock_s has been continuously high.
    bit mq[$];
    int m_run  = 0;
    int m_hi   = 0;
    int m_loss = 0;
    bit m_core = 1'b0;
    bit m_run_st = 1'b0;
    bit m_pix  = 1'b0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic rn, input logic lk);
        bit l;
        if (!rn) begin
            mq.delete();
            for (int i = 0; i < SYNC; i++) mq.push_back(1'b0);
            m_run = 0; m_hi = 0; m_loss = 0;
            m_core = 1'b0; m_run_st = 1'b0; m_pix = 1'b0;
        end else begin
            l = mq.pop_front();
            mq.push_back(lk);
            if (l) begin
                if (m_run < 1000000) m_run++;
            end else begin
                if (m_core && m_loss < 255) m_loss++;
                m_run = 0;
            end
            m_core   = (m_run >= STABLE + 1);
            m_run_st = (m_run >= STABLE + 1 + VIDEO);
            m_hi     = m_core ? m_hi + 1 : 0;
            m_pix    = m_core && (m_hi % CEDIV == 0);
        end
    endtask

    task automatic tick(input logic rn, input logic lk);
        reset_n  = rn;
        pll_lock = lk;
        @(posedge clk);
        model_step(rn, lk);
        #1;
        check("core_rst_n", core_rst_n, m_core);
        check("video_rst_n", video_rst_n, m_run_st);
        check("ready", ready, m_run_st);
        check("pix_ce", pix_ce, m_pix);
`ifdef LOCK_LOSS_CNT_EN
        check("lock_loss_cnt", lock_loss_cnt, m_loss);
`endif
    endtask

    initial begin
        int rise;
        int vrise;
        int fall;
        int npix;
        int hi;
        int lo;

        for (int i = 0; i < SYNC; i++) mq.push_back(1'b0);

        // Reset, then lock held from edge 0.
        repeat (3) tick(1'b0, 1'b0);
        rise = -1; vrise = -1; npix = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 1'b1);
            if (core_rst_n === 1'b1 && rise < 0) rise = i;
            if (video_rst_n === 1'b1 && vrise < 0) vrise = i;
            if (pix_ce === 1'b1) npix++;
        end
        check("core_rise_edge", rise, 10);
        check("video_rise_edge", vrise, 14);
        check("pix_pulse_count", npix, 6);

        // One-cycle lock glitch while stab_cnt is 5.
        repeat (2) tick(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        rise = -1;
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 1'b1);
            if (core_rst_n === 1'b1 && rise < 0) rise = i;
        end
        check("glitch_core_rise", rise, 10);

        // Lock lost in RUN.
        fall = -1;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0);
            if (core_rst_n === 1'b0 && fall < 0) fall = i;
        end
        check("loss_core_fall", fall, 2);
`ifdef LOCK_LOSS_CNT_EN
        check("loss_count_one", lock_loss_cnt, 1);
`endif

        // reset_n pulse during RUN with lock held.
        repeat (20) tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        rise = -1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b1);
            if (core_rst_n === 1'b1 && rise < 0) rise = i;
        end
        check("rst_core_rise", rise, 10);

        // Random lock run lengths with occasional resets.
        for (int b = 0; b < 100; b++) begin
            hi = $urandom_range(1, 30);
            lo = $urandom_range(1, 4);
            repeat (hi) tick(1'b1, 1'b1);
            repeat (lo) tick(1'b1, 1'b0);
            if ($urandom_range(0, 9) == 0) tick(1'b0, 1'($urandom_range(0, 1)));
        end

`ifdef LOCK_LOSS_CNT_EN
        // Saturation: 300 losses from CORE/RUN.
        tick(1'b0, 1'b0);
        for (int n = 0; n < 300; n++) begin
            repeat (18) tick(1'b1, 1'b1);
            repeat (2) tick(1'b1, 1'b0);
        end
        check("loss_saturate", lock_loss_cnt, 255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
